// File: rtl/fb_shift_reg_gen.sv
// Feedback shift register with run-time selectable feedback mode
// (Fibonacci LFSR, Galois LFSR, ring, Johnson), parallel seed load,
// all-zero lock-up recovery for the LFSR modes and period measurement
// against the last seeded reference value.
//
// mode | meaning
// -----+---------------------------------------------
//  0   | Fibonacci LFSR, feedback = parity(out & TAPS)
//  1   | Galois LFSR, shift right, xor TAPS when lsb=1
//  2   | ring (rotate left), all-zero simply holds
//  3   | Johnson (rotate left with inverted msb)
module fb_shift_reg_gen #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
    parameter logic [WIDTH-1:0] SEED  = 8'h01
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] out,
    output logic             lockup,
    output logic             wrap,
    output logic [WIDTH-1:0] period
);

    localparam logic [1:0]       MODE_FIB  = 2'd0;
    localparam logic [1:0]       MODE_GAL  = 2'd1;
    localparam logic [1:0]       MODE_RING = 2'd2;
    localparam logic [1:0]       MODE_JOHN = 2'd3;
    localparam logic [WIDTH-1:0] ALL_ONES  = '1;

    logic [WIDTH-1:0] ref_q;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] step_val;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] cnt_inc;

    // All-zero is a dead state only for the two LFSR modes.
    assign lockup = (mode == MODE_FIB || mode == MODE_GAL) && (out == '0);

    // Next state for one step in the selected mode, with lock-up recovery.
    always_comb begin
        step_val = out;
        case (mode)
            MODE_FIB:  step_val = {out[WIDTH-2:0], ^(out & TAPS)};
            MODE_GAL:  step_val = (out >> 1) ^ (out[0] ? TAPS : '0);
            MODE_RING: step_val = {out[WIDTH-2:0], out[WIDTH-1]};
            MODE_JOHN: step_val = {out[WIDTH-2:0], ~out[WIDTH-1]};
            default:   step_val = out;
        endcase
        nxt = lockup ? SEED : step_val;
    end

    // Saturating step counter increment, shared by cnt and period updates.
    always_comb begin
        cnt_inc = (cnt_q == ALL_ONES) ? ALL_ONES : cnt_q + 1'b1;
    end

    // State, reference, period measurement and wrap pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out    <= SEED;
            ref_q  <= SEED;
            cnt_q  <= '0;
            period <= '0;
            wrap   <= 1'b0;
        end else if (load) begin
            out   <= seed_in;
            ref_q <= seed_in;
            cnt_q <= '0;
            wrap  <= 1'b0;
        end else if (en) begin
            out <= nxt;
            if (nxt == ref_q) begin
                period <= cnt_inc;
                cnt_q  <= '0;
                wrap   <= 1'b1;
            end else begin
                cnt_q <= cnt_inc;
                wrap  <= 1'b0;
            end
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fb_shift_reg_gen.sv
// Directed bench for fb_shift_reg_gen at WIDTH=4, TAPS=4'hC, SEED=4'h1.
module tb_fb_shift_reg_gen;

    localparam int W = 4;

    localparam logic [3:0] FIB_SEQ [15] = '{
        4'b0010, 4'b0100, 4'b1001, 4'b0011, 4'b0110, 4'b1101, 4'b1010, 4'b0101,
        4'b1011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0001};
    localparam logic [3:0] GAL_SEQ [15] = '{
        4'b1100, 4'b0110, 4'b0011, 4'b1101, 4'b1010, 4'b0101, 4'b1110, 4'b0111,
        4'b1111, 4'b1011, 4'b1001, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
    localparam logic [3:0] RING_SEQ [8] = '{
        4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    localparam logic [3:0] JOHN_SEQ [8] = '{
        4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] seed_in = '0;
    logic [1:0]   mode = 2'd0;
    logic [W-1:0] out;
    logic         lockup;
    logic         wrap;
    logic [W-1:0] period;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fb_shift_reg_gen #(
        .WIDTH(W),
        .TAPS (4'hC),
        .SEED (4'h1)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .load   (load),
        .seed_in(seed_in),
        .mode   (mode),
        .out    (out),
        .lockup (lockup),
        .wrap   (wrap),
        .period (period)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock with the given controls; outputs are sampled 1 ns after the edge.
    task automatic tick(input logic e, input logic l, input logic [W-1:0] s);
        en      = e;
        load    = l;
        seed_in = s;
        @(posedge clk);
        #1;
        en   = 1'b0;
        load = 1'b0;
    endtask

    initial begin
        // Reset state
        mode = 2'd0;
        rst  = 1'b0;
        tick(1'b1, 1'b0, '0);
        tick(1'b0, 1'b0, '0);
        chk("rst_out", out, 4'h1);
        chk("rst_period", period, 4'h0);
        chk("rst_wrap", wrap, 1'b0);
        chk("rst_lockup", lockup, 1'b0);
        rst = 1'b1;

        // T1: Fibonacci from reset
        for (int i = 0; i < 15; i++) begin
            tick(1'b1, 1'b0, '0);
            chk($sformatf("fib_out%0d", i), out, FIB_SEQ[i]);
            chk($sformatf("fib_wrap%0d", i), wrap, (i == 14));
        end
        chk("fib_period", period, 4'd15);
        tick(1'b0, 1'b0, '0);
        chk("fib_wrap_idle", wrap, 1'b0);

        // T2: Galois after load
        mode = 2'd1;
        tick(1'b0, 1'b1, 4'h1);
        chk("gal_load", out, 4'h1);
        chk("gal_period_kept", period, 4'd15);
        for (int i = 0; i < 15; i++) begin
            tick(1'b1, 1'b0, '0);
            chk($sformatf("gal_out%0d", i), out, GAL_SEQ[i]);
            chk($sformatf("gal_wrap%0d", i), wrap, (i == 14));
        end
        chk("gal_period", period, 4'd15);

        // T3: ring, then all-zero ring holds without recovery
        mode = 2'd2;
        tick(1'b0, 1'b1, 4'h1);
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, 1'b0, '0);
            chk($sformatf("ring_out%0d", i), out, RING_SEQ[i]);
            chk($sformatf("ring_wrap%0d", i), wrap, ((i % 4) == 3));
        end
        chk("ring_period", period, 4'd4);
        tick(1'b0, 1'b1, 4'h0);
        chk("ring0_lockup", lockup, 1'b0);
        tick(1'b1, 1'b0, '0);
        chk("ring0_out", out, 4'h0);
        chk("ring0_lockup_step", lockup, 1'b0);
        chk("ring0_wrap", wrap, 1'b1);
        chk("ring0_period", period, 4'd1);

        // T4: Johnson from zero
        mode = 2'd3;
        tick(1'b0, 1'b1, 4'h0);
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, 1'b0, '0);
            chk($sformatf("john_out%0d", i), out, JOHN_SEQ[i]);
            chk($sformatf("john_wrap%0d", i), wrap, (i == 7));
        end
        chk("john_period", period, 4'd8);

        // T5: lock-up in Fibonacci, recovery, then saturation across a mode change
        mode = 2'd0;
        tick(1'b0, 1'b1, 4'h0);
        chk("lk_lockup", lockup, 1'b1);
        tick(1'b0, 1'b0, '0);
        tick(1'b0, 1'b0, '0);
        chk("lk_hold_out", out, 4'h0);
        chk("lk_hold_lockup", lockup, 1'b1);
        tick(1'b1, 1'b0, '0);
        chk("lk_recover_out", out, 4'h1);
        chk("lk_recover_lockup", lockup, 1'b0);
        chk("lk_recover_wrap", wrap, 1'b0);
        for (int i = 0; i < 19; i++) tick(1'b1, 1'b0, '0);
        chk("sat_fib_out", out, 4'b0011);
        mode = 2'd3;
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, '0);
        chk("sat_pre_out", out, 4'b1000);
        chk("sat_pre_wrap", wrap, 1'b0);
        tick(1'b1, 1'b0, '0);
        chk("sat_out", out, 4'b0000);
        chk("sat_wrap", wrap, 1'b1);
        chk("sat_period", period, 4'd15);

        // T6: load beats en, reset beats load, en gating
        mode = 2'd0;
        tick(1'b0, 1'b1, 4'h1);
        tick(1'b1, 1'b0, '0);
        tick(1'b1, 1'b1, 4'h9);
        chk("ld_en_out", out, 4'h9);
        chk("ld_en_wrap", wrap, 1'b0);
        tick(1'b1, 1'b0, '0);
        chk("ld_step_out", out, 4'b0011);
        rst = 1'b0;
        tick(1'b1, 1'b1, 4'h6);
        chk("rst_mid_out", out, 4'h1);
        chk("rst_mid_period", period, 4'h0);
        chk("rst_mid_wrap", wrap, 1'b0);
        rst = 1'b1;
        tick(1'b1, 1'b0, '0);
        chk("tog_out1", out, 4'b0010);
        tick(1'b0, 1'b0, '0);
        chk("tog_out2", out, 4'b0010);
        chk("tog_wrap2", wrap, 1'b0);
        tick(1'b1, 1'b0, '0);
        chk("tog_out3", out, 4'b0100);
        tick(1'b0, 1'b0, '0);
        chk("tog_out4", out, 4'b0100);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
